// File: rtl/ws_bit_receiver.sv
// Pulse-width decoder for a single-wire WS2812-style stream: measures each
// high/low phase, turns high pulses into bits, packs bits into pixel words.
module ws_bit_receiver #(
    parameter logic [15:0] L_TIME    = 16'd80,
    parameter logic [15:0] S_TIME    = 16'd40,
    parameter logic [15:0] R_TIME    = 16'd150,
    parameter int          WORD_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 led_stripe_pin,
    output logic                 bit_valid,
    output logic                 rx_bit,
    output logic                 pixel_valid,
    output logic [WORD_BITS-1:0] pixel_data,
    output logic                 frame_end,
    output logic                 frame_err,
    output logic                 pulse_err,
    output logic [1:0]           state_dbg,
    output logic [15:0]          high_cnt_dbg,
    output logic [15:0]          low_cnt_dbg,
    output logic [4:0]           bit_cnt_dbg
);

    localparam logic [16:0] LS_SUM   = {1'b0, L_TIME} + {1'b0, S_TIME};
    localparam logic [15:0] THRESH   = LS_SUM[16:1];
    localparam logic [15:0] MIN_HIGH = {1'b0, S_TIME[15:1]};
    localparam logic [16:0] MAX_HIGH = {L_TIME, 1'b0};
    localparam logic [4:0]  LAST_BIT = 5'(WORD_BITS - 1);
    localparam int          SYNC_STAGES = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    // Stage 0/1 form the synchroniser, stage 2 is the edge-detect delay.
    // vld_reg tracks which stages hold a genuinely sampled pin value since reset.
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] vld_reg;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rstn) begin
                    sync_reg[gi] <= 1'b0;
                    vld_reg[gi]  <= 1'b0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= led_stripe_pin;
                    vld_reg[gi]  <= 1'b1;
                end else begin
                    sync_reg[gi] <= sync_reg[gi-1];
                    vld_reg[gi]  <= vld_reg[gi-1];
                end
            end
        end
    endgenerate

    logic din_s, din_d, rise, fall;
    assign din_s = sync_reg[1];
    assign din_d = sync_reg[2];
    assign rise  = din_s & ~din_d;
    assign fall  = ~din_s & din_d;

    state_t                 state_reg, state_next;
    logic [15:0]            high_cnt_reg, high_cnt_next;
    logic [15:0]            low_cnt_reg, low_cnt_next;
    logic [4:0]             bit_cnt_reg, bit_cnt_next;
    logic [WORD_BITS-1:0]   shift_reg, shift_next;
    logic [WORD_BITS-1:0]   pixel_data_reg, pixel_data_next;
    logic                   rx_bit_reg, rx_bit_next;
    logic                   bit_valid_reg, bit_valid_next;
    logic                   pixel_valid_reg, pixel_valid_next;
    logic                   frame_end_reg, frame_end_next;
    logic                   frame_err_reg, frame_err_next;
    logic                   pulse_err_reg, pulse_err_next;
    logic                   arm_reg, arm_next;
    logic                   new_bit;

    always_comb begin
        state_next       = state_reg;
        high_cnt_next    = high_cnt_reg;
        low_cnt_next     = low_cnt_reg;
        bit_cnt_next     = bit_cnt_reg;
        shift_next       = shift_reg;
        pixel_data_next  = pixel_data_reg;
        rx_bit_next      = rx_bit_reg;
        bit_valid_next   = 1'b0;
        pixel_valid_next = 1'b0;
        frame_end_next   = 1'b0;
        frame_err_next   = 1'b0;
        pulse_err_next   = 1'b0;
        new_bit          = (high_cnt_reg >= THRESH);
        // A rise only counts once the line has really been seen low after reset.
        arm_next         = arm_reg | (vld_reg[1] & ~din_s);

        case (state_reg)
            ST_IDLE: begin
                if (rise && arm_reg) begin
                    state_next    = ST_HIGH;
                    high_cnt_next = 16'd1;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_next   = ST_LOW;
                    low_cnt_next = 16'd1;
                    if ((high_cnt_reg < MIN_HIGH) || ({1'b0, high_cnt_reg} > MAX_HIGH)) begin
                        pulse_err_next = 1'b1;
                    end else begin
                        bit_valid_next = 1'b1;
                        rx_bit_next    = new_bit;
                        shift_next     = {shift_reg[WORD_BITS-2:0], new_bit};
                        if (bit_cnt_reg == LAST_BIT) begin
                            pixel_valid_next = 1'b1;
                            pixel_data_next  = {shift_reg[WORD_BITS-2:0], new_bit};
                            bit_cnt_next     = 5'd0;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 5'd1;
                        end
                    end
                end else if (din_s && (high_cnt_reg != 16'hFFFF)) begin
                    high_cnt_next = high_cnt_reg + 16'd1;
                end
            end
            ST_LOW: begin
                if (low_cnt_reg != 16'hFFFF) begin
                    low_cnt_next = low_cnt_reg + 16'd1;
                end
                if (low_cnt_reg == R_TIME) begin
                    frame_end_next = 1'b1;
                    frame_err_next = (bit_cnt_reg != 5'd0);
                    bit_cnt_next   = 5'd0;
                    shift_next     = '0;
                    state_next     = ST_IDLE;
                end
                // A rise on the gap boundary still reports the frame, then starts the next pulse.
                if (rise) begin
                    state_next    = ST_HIGH;
                    high_cnt_next = 16'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_reg       <= ST_IDLE;
            high_cnt_reg    <= 16'd0;
            low_cnt_reg     <= 16'd0;
            bit_cnt_reg     <= 5'd0;
            shift_reg       <= '0;
            pixel_data_reg  <= '0;
            rx_bit_reg      <= 1'b0;
            bit_valid_reg   <= 1'b0;
            pixel_valid_reg <= 1'b0;
            frame_end_reg   <= 1'b0;
            frame_err_reg   <= 1'b0;
            pulse_err_reg   <= 1'b0;
            arm_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            high_cnt_reg    <= high_cnt_next;
            low_cnt_reg     <= low_cnt_next;
            bit_cnt_reg     <= bit_cnt_next;
            shift_reg       <= shift_next;
            pixel_data_reg  <= pixel_data_next;
            rx_bit_reg      <= rx_bit_next;
            bit_valid_reg   <= bit_valid_next;
            pixel_valid_reg <= pixel_valid_next;
            frame_end_reg   <= frame_end_next;
            frame_err_reg   <= frame_err_next;
            pulse_err_reg   <= pulse_err_next;
            arm_reg         <= arm_next;
        end
    end

    assign bit_valid    = bit_valid_reg;
    assign rx_bit       = rx_bit_reg;
    assign pixel_valid  = pixel_valid_reg;
    assign pixel_data   = pixel_data_reg;
    assign frame_end    = frame_end_reg;
    assign frame_err    = frame_err_reg;
    assign pulse_err    = pulse_err_reg;
    assign state_dbg    = state_reg;
    assign high_cnt_dbg = high_cnt_reg;
    assign low_cnt_dbg  = low_cnt_reg;
    assign bit_cnt_dbg  = bit_cnt_reg;

endmodule

// File: tb/tb_ws_bit_receiver.sv
// Scoreboard bench: the stimulus tasks queue expected strobes with their cycle,
// a negedge monitor pops and compares whenever the receiver strobes.
module tb_ws_bit_receiver;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        led_stripe_pin = 1'b0;
    logic        bit_valid, rx_bit, pixel_valid, frame_end, frame_err, pulse_err;
    logic [23:0] pixel_data;
    logic [1:0]  state_dbg;
    logic [15:0] high_cnt_dbg, low_cnt_dbg;
    logic [4:0]  bit_cnt_dbg;

    ws_bit_receiver dut (
        .clk            (clk),
        .rstn           (rstn),
        .led_stripe_pin (led_stripe_pin),
        .bit_valid      (bit_valid),
        .rx_bit         (rx_bit),
        .pixel_valid    (pixel_valid),
        .pixel_data     (pixel_data),
        .frame_end      (frame_end),
        .frame_err      (frame_err),
        .pulse_err      (pulse_err),
        .state_dbg      (state_dbg),
        .high_cnt_dbg   (high_cnt_dbg),
        .low_cnt_dbg    (low_cnt_dbg),
        .bit_cnt_dbg    (bit_cnt_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [23:0] val;
    } exp_t;

    exp_t q_bit[$];
    exp_t q_pix[$];
    exp_t q_frm[$];
    exp_t q_perr[$];

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          model_cnt = 0;
    logic [23:0] model_word = 24'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_ev(string name, logic [23:0] act, exp_t e);
        n_checks++;
        if ((act !== e.val) || (cyc != e.cyc)) begin
            n_fail++;
            $display("FAIL %s: got %0h at cycle %0d, expected %0h at cycle %0d",
                     name, act, cyc, e.val, e.cyc);
        end else begin
            $display("ok   %s: %0h at cycle %0d", name, act, cyc);
        end
    endtask

    // Monitor: strobes are compared against queue heads; overdue heads count as missing.
    always @(negedge clk) begin
        if (!rstn) begin
            if (q_bit.size() > 0 && q_bit[0].cyc < cyc) begin
                chk("bit_missing", 32'd0, 32'd1);
                void'(q_bit.pop_front());
            end
            if (q_pix.size() > 0 && q_pix[0].cyc < cyc) begin
                chk("pixel_missing", 32'd0, 32'd1);
                void'(q_pix.pop_front());
            end
            if (q_frm.size() > 0 && q_frm[0].cyc < cyc) begin
                chk("frame_missing", 32'd0, 32'd1);
                void'(q_frm.pop_front());
            end
            if (q_perr.size() > 0 && q_perr[0].cyc < cyc) begin
                chk("pulse_err_missing", 32'd0, 32'd1);
                void'(q_perr.pop_front());
            end
            if (bit_valid) begin
                if (q_bit.size() == 0) chk("bit_unexpected", 32'd1, 32'd0);
                else chk_ev("bit", {23'd0, rx_bit}, q_bit.pop_front());
            end
            if (pixel_valid) begin
                if (q_pix.size() == 0) chk("pixel_unexpected", 32'd1, 32'd0);
                else chk_ev("pixel", pixel_data, q_pix.pop_front());
            end
            if (frame_end) begin
                if (q_frm.size() == 0) chk("frame_unexpected", 32'd1, 32'd0);
                else chk_ev("frame_err", {23'd0, frame_err}, q_frm.pop_front());
            end else if (frame_err) begin
                chk("frame_err_without_end", 32'd1, 32'd0);
            end
            if (pulse_err) begin
                if (q_perr.size() == 0) chk("pulse_err_unexpected", 32'd1, 32'd0);
                else chk_ev("pulse_err", 24'd0, q_perr.pop_front());
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bit cell; expectations derived from thresholds 20 / 60 / 160 and gap 150.
    task automatic pulse(int hi, int lo);
        int   k;
        logic b;
        led_stripe_pin = 1'b1;
        tick(hi);
        k = cyc;
        led_stripe_pin = 1'b0;
        if (hi < 20 || hi > 160) begin
            q_perr.push_back('{k + 3, 24'd0});
        end else begin
            b = (hi >= 60);
            q_bit.push_back('{k + 3, {23'd0, b}});
            model_word = {model_word[22:0], b};
            model_cnt++;
            if (model_cnt == 24) begin
                q_pix.push_back('{k + 3, model_word});
                model_cnt = 0;
            end
        end
        if (lo >= 150) begin
            q_frm.push_back('{k + 153, {23'd0, model_cnt != 0}});
            model_cnt = 0;
        end
        tick(lo);
    endtask

    task automatic send_bits(logic [23:0] w, int hi_idx, int lo_idx, int last_low);
        for (int i = hi_idx; i >= lo_idx; i--) begin
            if (i == lo_idx && last_low > 0) pulse(w[i] ? 80 : 40, last_low);
            else pulse(w[i] ? 80 : 40, w[i] ? 40 : 80);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with the line toggling
        rstn = 1'b1;
        led_stripe_pin = 1'b0;
        tick(1);
        led_stripe_pin = 1'b1;
        tick(1);
        led_stripe_pin = 1'b0;
        chk("rst_strobes", {26'd0, bit_valid, rx_bit, pixel_valid, frame_end, frame_err, pulse_err}, 32'd0);
        chk("rst_pixel", {8'd0, pixel_data}, 32'd0);
        chk("rst_state", {30'd0, state_dbg}, 32'd0);
        chk("rst_counts", {high_cnt_dbg, low_cnt_dbg} | {27'd0, bit_cnt_dbg}, 32'd0);
        rstn = 1'b0;
        tick(200);
        chk("idle_state", {30'd0, state_dbg}, 32'd0);

        // Single cells and the 59/60 classification boundary
        pulse(80, 40);
        pulse(40, 80);
        pulse(59, 61);
        pulse(60, 150);
        tick(10);

        // Full word, then gap; next word starts right on the gap boundary
        send_bits(24'hA5C3F0, 23, 0, 150);

        // Glitch and overlong pulses inside a word
        send_bits(24'h123456, 23, 16, 0);
        pulse(10, 40);
        chk("glitch_bit_cnt", {27'd0, bit_cnt_dbg}, 32'd8);
        send_bits(24'h123456, 15, 8, 0);
        pulse(200, 40);
        chk("overlong_bit_cnt", {27'd0, bit_cnt_dbg}, 32'd16);
        send_bits(24'h123456, 7, 0, 150);
        tick(10);

        // Partial word followed by the gap
        send_bits(24'hA80000, 23, 19, 150);
        tick(10);
        chk("partial_bit_cnt", {27'd0, bit_cnt_dbg}, 32'd0);
        send_bits(24'h00FF00, 23, 0, 150);
        tick(10);

        // Reset in the high phase of bit 12
        send_bits(24'h3C5A96, 23, 12, 0);
        led_stripe_pin = 1'b1;
        tick(30);
        rstn = 1'b1;
        tick(2);
        chk("midrst_state", {30'd0, state_dbg}, 32'd0);
        chk("midrst_bit_cnt", {27'd0, bit_cnt_dbg}, 32'd0);
        rstn = 1'b0;
        model_cnt = 0;
        model_word = 24'd0;
        tick(50);
        chk("held_high_ignored", {30'd0, state_dbg}, 32'd0);
        led_stripe_pin = 1'b0;
        tick(60);
        send_bits(24'h3C5A96, 23, 0, 200);
        tick(20);

        chk("bits_left", q_bit.size(), 32'd0);
        chk("pixels_left", q_pix.size(), 32'd0);
        chk("frames_left", q_frm.size(), 32'd0);
        chk("pulse_errs_left", q_perr.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ws_bit_receiver.md
Name: ws_bit_receiver

Overview:
Decodes a single-wire WS2812-style pulse-width stream, the same one the LED stripe driver transmits, back into bits and 24-bit pixel words. It measures the high and low time of each bit cell and classifies each high pulse as 0 or 1. It detects the reset (latch) gap and flags malformed pulses. It is used for loopback self-test of the stripe driver and to receive pixel data from an upstream controller.

Parameters:
L_TIME, 16'd80, long high time in clk cycles (bit 1 high phase / bit 0 low phase)
S_TIME, 16'd40, short high time in clk cycles (bit 0 high phase / bit 1 low phase)
R_TIME, 16'd150, minimum low time in clk cycles recognised as frame reset/latch
WORD_BITS, 24, bits per pixel word

Ports:
clk  input  1  system clock
rstn  input  1  synchronous reset, active-high (1 = reset), sampled on rising clk
led_stripe_pin  input  1  asynchronous serial line
bit_valid  output  1  one-cycle strobe: rx_bit holds a decoded bit
rx_bit  output  1  decoded bit value
pixel_valid  output  1  one-cycle strobe: pixel_data holds a complete word
pixel_data  output  WORD_BITS  assembled word, first received bit in MSB
frame_end  output  1  one-cycle strobe: reset gap detected
frame_err  output  1  one-cycle strobe: reset gap arrived with partial word
pulse_err  output  1  one-cycle strobe: high pulse out of tolerance, bit dropped
state_dbg  output  2  current FSM state
high_cnt_dbg  output  16  high-time counter
low_cnt_dbg  output  16  low-time counter
bit_cnt_dbg  output  5  bits held in the current word

Behaviour:
- Reset (rstn=1 at clk edge): all outputs 0, pixel_data 0, counters 0, bit_cnt 0, state IDLE, synchroniser flops 0.
- Input path: 2-flop synchroniser gives din_s, plus one delay flop din_d. rise = din_s & ~din_d. fall = ~din_s & din_d.
- Derived constants: THRESH = (L_TIME+S_TIME)/2 (default 60). MIN_HIGH = S_TIME/2 (20). MAX_HIGH = 2*L_TIME (160).
- FSM states: IDLE=0, HIGH=1, LOW=2.
  - IDLE: ignore the line until rise, then go to HIGH with high_cnt=1. A line that is already high after reset is ignored until it falls and rises again.
  - HIGH: high_cnt increments each cycle din_s=1 and saturates at 16'hFFFF. On fall, classify the pulse, go to LOW, and set low_cnt=1.
  - LOW: low_cnt increments each cycle and saturates. On rise, go to HIGH with high_cnt=1. When low_cnt reaches R_TIME, go to IDLE and clear bit_cnt.
- Classification, applied to the final high_cnt at fall:
  - high_cnt < MIN_HIGH or high_cnt > MAX_HIGH: pulse_err=1 for one cycle. No bit_valid. bit_cnt and shift register unchanged.
  - Otherwise rx_bit = (high_cnt >= THRESH). Boundary: 59 -> 0, 60 -> 1.
- Latency: bit_valid is registered and asserts 3 clk after the pin's falling edge (2 synchroniser stages + 1). rx_bit holds its value until the next bit_valid.
- Word assembly:
  - Each accepted bit shifts into the LSB of the shift register and increments bit_cnt.
  - On the WORD_BITS-th bit: pixel_valid and bit_valid assert in the same cycle, pixel_data updates, bit_cnt wraps to 0.
  - pixel_data holds its value between strobes.
- Reset gap: low_cnt == R_TIME in LOW gives frame_end=1 for one cycle. In the same cycle, frame_err=1 if bit_cnt != 0, and the partial word is discarded.
- A low time below R_TIME never ends the frame. Low-phase duration is not otherwise checked.
- frame_end never fires from IDLE. An idle line low after reset gives no strobes.
- Simultaneous events:
  - Rise in the same cycle low_cnt reaches R_TIME: frame_end still fires, then go to HIGH.
  - Reset mid-pulse or mid-word: immediate return to IDLE. No strobes for the truncated pulse.
- Debug outputs mirror the internal registers directly, with no added latency.

Test Plan:
- Hold rstn=1 for 2 cycles with the line toggling -> every output 0, state_dbg=0. Release with the line low for 200 cycles -> no strobes.
- One pulse: high 80 / low 40 -> bit_valid=1, rx_bit=1, 3 clk after fall. Then high 40 / low 80 -> rx_bit=0. Then high 59 -> 0 and high 60 -> 1.
- 24 bits of 0xA5C3F0 MSB first (80/40 and 40/80 cells), then low 150 -> 24 bit_valid strobes, one pixel_valid with pixel_data=24'hA5C3F0, frame_end=1, frame_err=0.
- Glitch high 10 cycles inside a word, and overlong high 200 cycles -> pulse_err each time, no bit_valid, bit_cnt_dbg unchanged. The word still completes correctly afterwards.
- 5 bits then low 150 -> frame_end=1 and frame_err=1 in the same cycle, bit_cnt_dbg=0. The following 24-bit word 0x00FF00 decodes cleanly.
- Assert rstn during the high phase of bit 12 while the line stays high, then release -> no bit_valid until a fresh rise. A new 24-bit word decodes as sent.
